// File: rtl/opc1_pkg.sv
// Shared OPC1 constants: bus widths, CPU reset vector and boot-memory state codes.
package opc1_pkg;

    localparam int unsigned OPC1_ADDR_W    = 11;
    localparam int unsigned OPC1_DATA_W    = 8;
    localparam logic [10:0] OPC1_RESET_VEC = 11'h100;

    typedef logic [1:0] bm_state_t;

    localparam bm_state_t ST_HOLD    = 2'd0;
    localparam bm_state_t ST_LOAD    = 2'd1;
    localparam bm_state_t ST_RELEASE = 2'd2;
    localparam bm_state_t ST_RUN     = 2'd3;

endpackage

// File: rtl/opc1_ram_1w1ar.sv
// Single-write-port, asynchronous-read RAM; the loader port takes the write port over the CPU port.
module opc1_ram_1w1ar
    import opc1_pkg::*;
#(
    parameter int unsigned ADDR_W = OPC1_ADDR_W,
    parameter int unsigned DATA_W = OPC1_DATA_W
) (
    input  logic              clk_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        we    = cpu_we_i;
        waddr = cpu_addr_i;
        wdata = cpu_data_i;
        if (ld_we_i) begin
            we    = 1'b1;
            waddr = ld_addr_i;
            wdata = ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/opc1_bootmem.sv
// OPC1 bus responder: 2 KB RAM plus boot-loader FSM holding the CPU in reset while an image streams in.
// Define OPC1_BOOTMEM_WPROT_EN to drop CPU writes into the loaded image window.
module opc1_bootmem
    import opc1_pkg::*;
#(
    parameter int unsigned       ADDR_W    = OPC1_ADDR_W,
    parameter int unsigned       DATA_W    = OPC1_DATA_W,
    parameter logic [ADDR_W-1:0] LOAD_BASE = ADDR_W'(OPC1_RESET_VEC),
    parameter int unsigned       LOAD_LEN  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              rnw,
    inout  logic [DATA_W-1:0] data,
    output logic              cpu_reset_b,
    input  logic              go,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done
);

    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_LEN - 1);

    bm_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rstb_q, rstb_d;
    logic              done_q, done_d;
    logic              in_run, ld_accept, cpu_we, wprot;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] rd_data;

    assign in_run    = (state_q == ST_RUN);
    assign ld_ready  = (state_q == ST_LOAD);
    assign ld_accept = ld_ready && ld_valid;
    assign ld_addr   = LOAD_BASE + cnt_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (go) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_LOAD: begin
                if (ld_accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_RELEASE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_HOLD;
        endcase
        // CPU reset is registered from the next state so it deasserts on entry to RUN.
        rstb_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            rstb_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rstb_q  <= rstb_d;
            done_q  <= done_d;
        end
    end

    assign cpu_reset_b = rstb_q;
    assign ld_done     = done_q;

`ifdef OPC1_BOOTMEM_WPROT_EN
    logic [ADDR_W-1:0] wp_off;
    assign wp_off = address - LOAD_BASE;
    assign wprot  = ({1'b0, wp_off} < CNT_W'(LOAD_LEN));
`else
    assign wprot  = 1'b0;
`endif

    assign cpu_we = in_run && !rnw && !wprot;
    assign data   = (in_run && rnw) ? rd_data : 'z;

    opc1_ram_1w1ar #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i      (clk),
        .ld_we_i    (ld_accept),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .cpu_we_i   (cpu_we),
        .cpu_addr_i (address),
        .cpu_data_i (data),
        .rd_addr_i  (address),
        .rd_data_o  (rd_data)
    );

endmodule

// File: tb/tb_opc1_bootmem.sv
// Directed/random bench for opc1_bootmem: default instance plus a wrapping 0x7F0/32-byte instance.
module tb_opc1_bootmem;

    localparam int M_HOLD = 0;
    localparam int M_LOAD = 1;
    localparam int M_REL  = 2;
    localparam int M_RUN  = 3;
`ifdef OPC1_BOOTMEM_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, go, ld_start, ld_valid, rnw, tb_wen;
    logic [7:0]  ld_data, tb_wdata;
    logic [10:0] address;
    wire  [7:0]  data0, data1;
    logic        rstb0, rstb1, rdy0, rdy1, done0, done1;
    logic [1:0]  rdy_v, done_v, rstb_v;

    assign data0  = tb_wen ? tb_wdata : 'z;
    assign data1  = tb_wen ? tb_wdata : 'z;
    assign rdy_v  = {rdy1, rdy0};
    assign done_v = {done1, done0};
    assign rstb_v = {rstb1, rstb0};

    opc1_bootmem dut (
        .clk(clk), .reset(reset), .address(address), .rnw(rnw), .data(data0),
        .cpu_reset_b(rstb0), .go(go), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(rdy0), .ld_done(done0)
    );

    opc1_bootmem #(.LOAD_BASE(11'h7F0), .LOAD_LEN(32)) dut_wrap (
        .clk(clk), .reset(reset), .address(address), .rnw(rnw), .data(data1),
        .cpu_reset_b(rstb1), .go(go), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(rdy1), .ld_done(done1)
    );

    // Reference model: phase, byte count and RAM image per instance.
    int unsigned m_base [2] = '{32'h100, 32'h7F0};
    int unsigned m_len  [2] = '{256, 32};
    int          m_ph   [2];
    int unsigned m_cnt  [2];
    bit          m_fromld [2];
    logic [7:0]  m_mem   [2][2048];
    bit          m_known [2][2048];
    int unsigned done_seen [2];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_prot(input int k, input int unsigned a);
        return WPROT_ON && (((a + 2048 - m_base[k]) % 2048) < m_len[k]);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ph[k] = M_HOLD; m_cnt[k] = 0; m_fromld[k] = 1'b0;
            end else begin
                case (m_ph[k])
                    M_HOLD: begin
                        if (ld_start) begin
                            m_ph[k] = M_LOAD; m_cnt[k] = 0;
                        end else if (go) begin
                            m_ph[k] = M_REL; m_fromld[k] = 1'b0;
                        end
                    end
                    M_LOAD: begin
                        if (ld_valid) begin
                            int unsigned a;
                            a = (m_base[k] + m_cnt[k]) % 2048;
                            m_mem[k][a] = ld_data;
                            m_known[k][a] = 1'b1;
                            m_cnt[k]++;
                            if (m_cnt[k] == m_len[k]) begin
                                m_ph[k] = M_REL; m_fromld[k] = 1'b1;
                            end
                        end
                    end
                    M_REL: m_ph[k] = M_RUN;
                    default: begin
                        if (!rnw && tb_wen && !is_prot(k, 32'(address))) begin
                            m_mem[k][address] = tb_wdata;
                            m_known[k][address] = 1'b1;
                        end
                        if (ld_start) begin
                            m_ph[k] = M_LOAD; m_cnt[k] = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    // Check all outputs against the model at the negedge, then advance one clock.
    task automatic cycle();
        logic [7:0] rd [2];
        @(negedge clk);
        rd[0] = data0;
        rd[1] = data1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ld_ready%0d", k), 32'(rdy_v[k]), 32'(m_ph[k] == M_LOAD));
            check($sformatf("ld_done%0d", k), 32'(done_v[k]), 32'(m_ph[k] == M_REL && m_fromld[k]));
            check($sformatf("cpu_reset_b%0d", k), 32'(rstb_v[k]), 32'(m_ph[k] == M_RUN));
            if (m_ph[k] == M_RUN && rnw && !tb_wen && m_known[k][address])
                check($sformatf("read%0d@%0h", k, address), 32'(rd[k]), 32'(m_mem[k][address]));
            if (done_v[k]) done_seen[k]++;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic stream(input int unsigned n, input bit rand_mode);
        int unsigned acc = 0;
        int unsigned guard = 0;
        while (acc < n && guard < 4 * n + 20) begin
            ld_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = rand_mode ? 8'($urandom) : 8'(acc + 1);
            if (ld_valid && m_ph[0] == M_LOAD) acc++;
            cycle();
            guard++;
        end
        ld_valid = 1'b0;
        check("stream_accepted", acc, n);
    endtask

    task automatic sweep(input int unsigned start, input int unsigned n);
        rnw = 1'b1;
        tb_wen = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            address = 11'((start + i) % 2048);
            cycle();
        end
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
        address = a; rnw = 1'b0; tb_wen = 1'b1; tb_wdata = d;
        cycle();
        rnw = 1'b1; tb_wen = 1'b0;
    endtask

    initial begin
        int unsigned done_before;
        reset = 1'b1; go = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        rnw = 1'b1; tb_wen = 1'b0; tb_wdata = '0; address = '0;
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = M_HOLD; m_cnt[k] = 0; m_fromld[k] = 1'b0; done_seen[k] = 0;
            for (int a = 0; a < 2048; a++) m_known[k][a] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;
        cycle();

        // Sequential image i+1, continuous valid.
        ld_start = 1'b1; cycle(); ld_start = 1'b0;
        stream(256, 1'b0);
        check("t1_release_rstb", 32'(rstb0), 32'd0);
        cycle(); cycle();
        check("t1_run_rstb", 32'(rstb0), 32'd1);
        check("t1_done_pulses", done_seen[0], 32'd1);
        check("t1_wrap_done_pulses", done_seen[1], 32'd1);
        sweep(32'h100, 256);
        sweep(32'h7F0, 32);
        address = 11'h000; #2;
        check("t5_wrap_byte16", 32'(data1), 32'h11);

        // Zero-latency read, then CPU write/readback.
        address = 11'h105; rnw = 1'b1; #2;
        check("t3_read_105", 32'(data0), 32'h06);
        cycle();
        cpu_write(11'h010, 8'hA5);
        address = 11'h010; #2;
        check("t3_read_010", 32'(data0), 32'hA5);
        cycle();

        // Write into the image window and outside it.
        cpu_write(11'h100, 8'hFF);
        address = 11'h100; #2;
        check("t6_read_100", 32'(data0), WPROT_ON ? 32'h01 : 32'hFF);
        cycle();
        cpu_write(11'h020, 8'h5A);
        address = 11'h020; #2;
        check("t6_read_020", 32'(data0), 32'h5A);
        cycle();

        // Reload from RUN with random valid gaps.
        ld_start = 1'b1; cycle(); ld_start = 1'b0;
        stream(256, 1'b1);
        repeat (3) cycle();
        check("t2_done_pulses", done_seen[0], 32'd2);
        sweep(32'h100, 256);
        sweep(32'h7F0, 32);

        // Reset mid-load, then a fresh load.
        done_before = done_seen[0];
        ld_start = 1'b1; cycle(); ld_start = 1'b0;
        stream(10, 1'b1);
        reset = 1'b1; cycle(); reset = 1'b0;
        cycle();
        check("t4_rstb_after_reset", 32'(rstb0), 32'd0);
        check("t4_no_done", done_seen[0], done_before);
        ld_start = 1'b1; cycle(); ld_start = 1'b0;
        stream(256, 1'b1);
        repeat (3) cycle();
        sweep(32'h100, 256);

        // go release without loading; RAM survives reset.
        done_before = done_seen[0];
        reset = 1'b1; cycle(); reset = 1'b0;
        go = 1'b1; cycle(); go = 1'b0;
        cycle(); cycle();
        check("t5_go_rstb", 32'(rstb0), 32'd1);
        check("t5_go_no_done", done_seen[0], done_before);
        sweep(32'h100, 256);
        sweep(32'h7F0, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
